debounce_multi: RTL
===================

Name: debounce_multi

Overview:
- Parametrised successor to the fixed 6-button/16-switch debouncer.
- Debounces NUM_CH raw inputs with a configurable sample depth, per-channel polarity inversion and a configurable reset value.
- Adds input synchronisation, one-clock press/release pulses, and long-press detection with auto-repeat pulses.
- Sits between the board pin inputs and the game/robot control logic, which consumes the levels, pulses and repeats directly.

Parameters:
- CLK_FREQUENCY_HZ, 100000000, system clock frequency.
- DEBOUNCE_FREQUENCY_HZ, 250, sample tick rate.
- CNTR_WIDTH, 32, width of the tick divider counter.
- SIMULATE, 0, 1 = use SIMULATE_FREQUENCY_CNT as the divider top.
- SIMULATE_FREQUENCY_CNT, 5, divider top in simulation.
- NUM_CH, 22, number of input channels (1..64).
- SAMPLE_DEPTH, 4, consecutive equal samples required to change output (2..16).
- INVERT_MASK, {NUM_CH{1'b0}}, bit i = 1: channel i is active-low at the pin and is inverted before debouncing.
- RESET_VALUE, {NUM_CH{1'b0}}, post-inversion value of db_out and all history bits at reset.
- HOLD_TICKS, 125, ticks of continuous assertion before hold/first repeat; 0 disables hold and repeat.
- REPEAT_TICKS, 25, ticks between subsequent repeat pulses; 0 gives a single repeat at hold onset only.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- raw_in  in  NUM_CH  raw pin inputs, asynchronous to clk.
- db_out  out  NUM_CH  debounced, polarity-corrected levels.
- rise_pulse  out  NUM_CH  one-clk pulse on a db_out 0->1 transition.
- fall_pulse  out  NUM_CH  one-clk pulse on a db_out 1->0 transition.
- hold  out  NUM_CH  level; high while the channel has been asserted for at least HOLD_TICKS ticks.
- repeat_pulse  out  NUM_CH  one-clk auto-repeat pulse.
- tick  out  1  one-clk sample strobe, for debug and bench alignment.

Behaviour:
- Reset: while reset_n=0, all state is forced immediately (asynchronous) and held:
  - divider = 0; tick = 0.
  - Synchroniser flops = RESET_VALUE^INVERT_MASK.
  - History registers = all bits RESET_VALUE[i].
  - db_out = RESET_VALUE; db_prev = RESET_VALUE; rise/fall/repeat = 0; hold = 0; hold counters = 0.
  - Release is recognised on the first clk edge with reset_n=1.
- Synchroniser: two flops per channel. s[i] = sync2[i] ^ INVERT_MASK[i].
- Divider:
  - TOP = SIMULATE ? SIMULATE_FREQUENCY_CNT : CLK_FREQUENCY_HZ/DEBOUNCE_FREQUENCY_HZ - 1.
  - Counts 0..TOP, then wraps to 0.
  - tick is registered, high for the one clk following the cycle where count==TOP.
  - Tick period = TOP+1 clks.
- History: on each tick, hist[i] <= {hist[i][SAMPLE_DEPTH-2:0], s[i]}.
- Level update, evaluated every clk:
  - hist all ones -> db_out[i] <= 1.
  - hist all zeros -> db_out[i] <= 0.
  - Otherwise db_out[i] holds.
  - db_out therefore changes one clk after the SAMPLE_DEPTH-th consecutive equal sample is shifted in.
  - Worst-case latency from a pin edge = 2 sync clks + SAMPLE_DEPTH ticks + 1 clk.
  - A glitch shorter than SAMPLE_DEPTH ticks never changes db_out.
- Edge pulses:
  - db_prev <= db_out every clk.
  - rise = db_out & ~db_prev; fall = ~db_out & db_prev.
  - Each is exactly one clk, in the first cycle of the new level.
  - No pulses are generated by reset release.
- Hold/repeat, per channel, hold counter hc and state IDLE/ARMED/HELD:
  - IDLE (db_out=0): hc=0, hold=0.
  - rise -> ARMED, hc=0.
  - ARMED: on tick hc++. When hc reaches HOLD_TICKS -> HELD, hold=1, one repeat_pulse, hc=0.
  - HELD: on tick hc++. When hc reaches REPEAT_TICKS (REPEAT_TICKS>0) -> repeat_pulse, hc=0.
  - hc saturates and never wraps.
  - db_out=0 in any state -> IDLE in the same cycle, hold=0, no repeat that cycle. Release wins over a simultaneous hold or repeat event.
  - HOLD_TICKS=0: channel stays in IDLE; hold and repeat_pulse are tied 0.
- Channels are fully independent. Simultaneous events on different channels are each reported in the same cycle.

Test Plan:
(Config for all lines: SIMULATE=1, SIMULATE_FREQUENCY_CNT=3 (tick every 4 clks), NUM_CH=4, SAMPLE_DEPTH=4, HOLD_TICKS=6, REPEAT_TICKS=2.)
- Reset: assert reset_n=0 mid-hold on ch0 -> db_out=RESET_VALUE, hold=0, no pulses, within the same cycle. Release -> no rise/fall pulse.
- Clean press: raw_in[1] 0->1 and held -> db_out[1] rises after 2 sync clks + 4 ticks + 1 clk, with rise_pulse[1] high exactly 1 clk. Release gives fall_pulse[1] symmetrically.
- Glitch rejection: raw_in[2] high for 3 ticks, then low -> db_out[2] stays 0, no pulses. High for exactly 4 ticks -> db_out[2] goes 1.
- Polarity: INVERT_MASK=4'b1000, RESET_VALUE=0, raw_in[3] held at 1 -> db_out[3]=0. Drive raw_in[3]=0 stable -> db_out[3]=1 plus rise_pulse[3].
- Hold/repeat: ch0 held 14 ticks after db_out rise -> hold high and repeat at tick 6, repeats at ticks 8, 10, 12, 14 (5 total). Release -> hold=0 in the cycle db_out falls.
- Release vs repeat: schedule db_out[0] fall in the same cycle as the tick-8 repeat -> no repeat_pulse, fall_pulse=1, state IDLE.

Source files
------------

// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel debouncer with sync, polarity, edge pulses and long-press hold/auto-repeat
module debounce_multi #(
  parameter int                CLK_FREQUENCY_HZ       = 100000000,
  parameter int                DEBOUNCE_FREQUENCY_HZ  = 250,
  parameter int                CNTR_WIDTH             = 32,
  parameter int                SIMULATE               = 0,
  parameter int                SIMULATE_FREQUENCY_CNT = 5,
  parameter int                NUM_CH                 = 22,
  parameter int                SAMPLE_DEPTH           = 4,
  parameter logic [NUM_CH-1:0] INVERT_MASK            = '0,
  parameter logic [NUM_CH-1:0] RESET_VALUE            = '0,
  parameter int                HOLD_TICKS             = 125,
  parameter int                REPEAT_TICKS           = 25
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] db_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] hold,
  output logic [NUM_CH-1:0] repeat_pulse,
  output logic              tick
);
  localparam logic [CNTR_WIDTH-1:0] TOP = (SIMULATE != 0) ? CNTR_WIDTH'(SIMULATE_FREQUENCY_CNT)
                                                           : CNTR_WIDTH'(CLK_FREQUENCY_HZ / DEBOUNCE_FREQUENCY_HZ - 1);
  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HW   = (HMAX < 1) ? 1 : $clog2(HMAX + 1);

  typedef enum logic [1:0] {IDLE, ARMED, HELD} state_e;

  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  tick_q, tick_d, tick_dly_q;
  logic [NUM_CH-1:0]     sync1_q, sync2_q, s;

  always_comb begin
    cnt_d  = (cnt_q == TOP) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_q == TOP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      tick_dly_q <= 1'b0;
      sync1_q    <= RESET_VALUE ^ INVERT_MASK;
      sync2_q    <= RESET_VALUE ^ INVERT_MASK;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      tick_dly_q <= tick_q;
      sync1_q    <= raw_in;
      sync2_q    <= sync1_q;
    end
  end

  assign tick = tick_q;
  assign s    = sync2_q ^ INVERT_MASK;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SAMPLE_DEPTH-1:0] hist_q, hist_d;
    logic                    db_q, db_d, prev_q;
    state_e                  state_q, state_d;
    logic [HW-1:0]           hc_q, hc_d, hc_inc;
    logic                    rep_q, rep_d;

    always_comb begin
      hist_d = tick_q ? {hist_q[SAMPLE_DEPTH-2:0], s[i]} : hist_q;
      db_d   = (&hist_q) ? 1'b1 : (~|hist_q) ? 1'b0 : db_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hist_q <= {SAMPLE_DEPTH{RESET_VALUE[i]}};
        db_q   <= RESET_VALUE[i];
        prev_q <= RESET_VALUE[i];
      end else begin
        hist_q <= hist_d;
        db_q   <= db_d;
        prev_q <= db_q;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        hc_q    <= '0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        hc_q    <= hc_d;
        rep_q   <= rep_d;
      end
    end

    // hold counting uses the delayed tick so hold/repeat events land in the same cycle as a db_out change
    always_comb begin
      state_d = state_q;
      hc_d    = hc_q;
      rep_d   = 1'b0;
      hc_inc  = (&hc_q) ? hc_q : hc_q + 1'b1;
      if (!db_q) begin
        state_d = IDLE;
        hc_d    = '0;
      end else begin
        case (state_q)
          IDLE: if (HOLD_TICKS != 0 && !prev_q) begin
            state_d = ARMED;
            hc_d    = '0;
          end
          ARMED: if (tick_dly_q) begin
            if (hc_inc == HW'(HOLD_TICKS)) begin
              state_d = HELD;
              hc_d    = '0;
              rep_d   = 1'b1;
            end else hc_d = hc_inc;
          end
          HELD: if (tick_dly_q) begin
            if (REPEAT_TICKS != 0 && hc_inc == HW'(REPEAT_TICKS)) begin
              hc_d  = '0;
              rep_d = 1'b1;
            end else hc_d = hc_inc;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // release wins: outputs are masked by the live level
    always_comb begin
      hold[i]         = db_q & (state_q == HELD);
      repeat_pulse[i] = db_q & rep_q;
    end

    assign db_out[i]     = db_q;
    assign rise_pulse[i] = db_q & ~prev_q;
    assign fall_pulse[i] = ~db_q & prev_q;
  end
endmodule
